pc_fetch_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer that sits directly upstream of the next-PC logic.
- Holds the architectural PC and fetches the instruction at that PC over a request/grant/response memory interface.
- Presents pc/inst to decode and the NPC stage.
- Loads the NPC stage's npc result when the downstream consumer releases stall.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/pc_fetch_unit_if.sv | 27 ++
 rtl/fetch_timeout_ctr.sv | 32 +++
 rtl/pc_fetch_unit.sv | 110 +++++++++++
 tb/tb_pc_fetch_unit.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC register / instruction-fetch slice.
// Compile-time option FETCH_ALIGN_CHECK_EN is consumed by pc_fetch_unit, not here.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } fetch_state_e;

  // Counter width for a limit of TIMEOUT; a disabled timeout still gets one bit.
  function automatic int ctr_width(int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Request/grant/response instruction-memory bus between the fetch unit (master)
// and instruction memory (slave).
interface pc_fetch_unit_if;

  logic                      imem_req;
  logic [fetch_pkg::XLEN-1:0] imem_addr;
  logic                      imem_gnt;
  logic                      imem_rvalid;
  logic [fetch_pkg::XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Saturating wait-cycle counter; expired flags the last permitted wait cycle.
// TIMEOUT=0 disables expiry entirely.
module fetch_timeout_ctr
  import fetch_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = ctr_width(TIMEOUT);
  localparam logic [W-1:0] LAST = (TIMEOUT == 0) ? '0 : W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // NOTE: reset is synchronous, so it lives inside the clocked block and all
  // state updates use non-blocking assignments to avoid ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (enable && (TIMEOUT != 0) && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC register and single-outstanding instruction fetch sequencer.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned npc instead of silently aligning it.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] npc,
  input  logic            stall,
  pc_fetch_unit_if.master imem,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  output logic            fetch_err,
  output logic            fetch_misalign
);

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic            req_q;
  logic            ctr_clear;
  logic            ctr_enable;
  logic            ctr_expired;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = fetch_pc;

  // Counter restarts on the accepted handshake and only counts empty wait cycles.
  assign ctr_clear  = (state == S_REQ) && req_q && imem.imem_gnt;
  assign ctr_enable = (state == S_WAIT) && !imem.imem_rvalid;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (ctr_clear),
    .enable  (ctr_enable),
    .expired (ctr_expired)
  );

`ifndef FETCH_ALIGN_CHECK_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  assign fetch_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_REQ;
      fetch_pc   <= RESET_PC;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_valid <= 1'b0;
      req_q      <= 1'b0;
      fetch_err  <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_misalign <= 1'b0;
`endif
    end else begin
      case (state)
        S_REQ: begin
          // Request is raised one cycle after reset release, then held until granted.
          if (req_q && imem.imem_gnt) begin
            req_q <= 1'b0;
            state <= S_WAIT;
          end else begin
            req_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            inst       <= imem.imem_rdata;
            pc         <= fetch_pc;
            inst_valid <= 1'b1;
            state      <= S_HOLD;
          end else if (ctr_expired) begin
            fetch_err <= 1'b1;
            state     <= S_ERR;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            inst_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (npc[1:0] != 2'b00) begin
              fetch_misalign <= 1'b1;
              state          <= S_ERR;
            end else begin
              fetch_pc <= npc;
              req_q    <= 1'b1;
              state    <= S_REQ;
            end
`else
            fetch_pc <= npc & ALIGN_MASK;
            req_q    <= 1'b1;
            state    <= S_REQ;
`endif
          end
        end
        default: begin
          // S_ERR: frozen until reset.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with TIMEOUT=16, RESET_PC=0.
// Works in both builds; the misaligned-npc step branches on FETCH_ALIGN_CHECK_EN.
module tb_pc_fetch_unit;
  import fetch_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] npc;
  logic            stall;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inst;
  logic            inst_valid;
  logic            fetch_err;
  logic            fetch_misalign;

  int passed = 0;
  int total  = 0;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .npc            (npc),
    .stall          (stall),
    .imem           (bus.master),
    .pc             (pc),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .fetch_err      (fetch_err),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance one rising edge; sample and drive 1 time unit later.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"},       pc,               32'h0);
    check({tag, "_inst"},     inst,             32'h0);
    check({tag, "_valid"},    {31'h0, inst_valid}, 32'h0);
    check({tag, "_req"},      {31'h0, bus.imem_req}, 32'h0);
    check({tag, "_err"},      {31'h0, fetch_err},  32'h0);
    check({tag, "_misalign"}, {31'h0, fetch_misalign}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    npc             = 32'h0;
    stall           = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    tick(2);
    check_reset_values("reset");

    // Basic fetch: grant held high from release, rvalid one cycle after grant.
    rst_n        = 1'b1;
    bus.imem_gnt = 1'b1;
    tick();
    check("req_after_release", {31'h0, bus.imem_req}, 32'h1);
    check("addr_reset_pc", bus.imem_addr, 32'h0);
    tick();
    check("req_drop_in_wait", {31'h0, bus.imem_req}, 32'h0);
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0013;
    tick();
    check("valid_3rd_edge", {31'h0, inst_valid}, 32'h1);
    check("pc_first", pc, 32'h0);
    check("inst_first", inst, 32'h0000_0013);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'hFFFF_FFFF;

    // Stall holds pc/inst for five cycles.
    npc   = 32'h0000_0004;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold", {inst_valid, pc[30:0]} ^ inst, 32'h8000_0013);
      check("stall_no_req", {31'h0, bus.imem_req}, 32'h0);
    end
    stall = 1'b0;
    tick();
    check("next_req", {31'h0, bus.imem_req}, 32'h1);
    check("next_addr", bus.imem_addr, 32'h0000_0004);
    check("valid_drop", {31'h0, inst_valid}, 32'h0);
    stall = 1'b1;  // no effect outside S_HOLD

    // Grant, then starve the response until timeout.
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    tick(15);
    check("no_err_before_limit", {31'h0, fetch_err}, 32'h0);
    tick();
    check("timeout_err", {31'h0, fetch_err}, 32'h1);
    check("timeout_valid", {31'h0, inst_valid}, 32'h0);
    check("timeout_req", {31'h0, bus.imem_req}, 32'h0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    tick(3);
    check("err_ignores_rvalid", {31'h0, inst_valid}, 32'h0);
    check("err_inst_frozen", inst, 32'h0000_0013);
    check("err_sticky", {31'h0, fetch_err}, 32'h1);
    check("err_req_low", {31'h0, bus.imem_req}, 32'h0);
    bus.imem_rvalid = 1'b0;
    rst_n = 1'b0;
    tick();
    check_reset_values("reset_after_err");

    // Response arriving on the 16th wait cycle beats the timeout.
    stall = 1'b0;
    rst_n = 1'b1;
    tick();
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    tick(15);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0010_0093;
    tick();
    check("late_rvalid_valid", {31'h0, inst_valid}, 32'h1);
    check("late_rvalid_err", {31'h0, fetch_err}, 32'h0);
    check("late_rvalid_inst", inst, 32'h0010_0093);
    bus.imem_rvalid = 1'b0;

    // Reset during S_WAIT; stale response afterwards is ignored.
    npc = 32'h0000_0008;
    tick();
    check("addr_8", bus.imem_addr, 32'h0000_0008);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n           = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_BAD0;
    tick(2);
    check("stale_valid", {31'h0, inst_valid}, 32'h0);
    check("stale_inst", inst, 32'h0);
    check("refetch_req", {31'h0, bus.imem_req}, 32'h1);
    check("refetch_addr", bus.imem_addr, 32'h0);
    bus.imem_rvalid = 1'b0;
    bus.imem_gnt    = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0013;
    tick();
    bus.imem_rvalid = 1'b0;
    check("refetch_inst", inst, 32'h0000_0013);

    // Misaligned next PC.
    npc = 32'h0000_0102;
    tick();
`ifdef FETCH_ALIGN_CHECK_EN
    check("misalign_flag", {31'h0, fetch_misalign}, 32'h1);
    check("misalign_no_req", {31'h0, bus.imem_req}, 32'h0);
    check("misalign_valid", {31'h0, inst_valid}, 32'h0);
    check("misalign_pc", pc, 32'h0);
    tick(2);
    check("misalign_still_no_req", {31'h0, bus.imem_req}, 32'h0);
`else
    check("aligned_req", {31'h0, bus.imem_req}, 32'h1);
    check("aligned_addr", bus.imem_addr, 32'h0000_0100);
    check("misalign_tied", {31'h0, fetch_misalign}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
